// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants and types for the pipeline hazard controller.
//   FWD_REGFILE      forward-select value meaning "read operand from the regfile"
//   hz_flags_t       per-stage flag record of the in-flight writer table
//   HZ_*_DEF         default parameter values used by hazard_ctrl
package hazard_ctrl_pkg;

  localparam int FWD_REGFILE        = 0;
  localparam int HZ_NUM_STAGES_DEF  = 2;
  localparam int HZ_REG_AW_DEF      = 5;
  localparam int HZ_LOAD_LAT_DEF    = 1;
  localparam int HZ_KILL_CYCLES_DEF = 1;

  // Flag part of one table entry. The destination register is stored in a
  // separate packed array because its width follows the REG_AW parameter.
  typedef struct packed {
    logic valid;
    logic we;
    logic is_load;
  } hz_flags_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// hazard_fwd_match: combinational priority match of one source operand
// against the in-flight writer table. Index 0 of the table arrays is stage 1
// (X); the youngest (lowest stage) matching writer wins.
//   rs, rs_used           operand address and whether it is actually read
//   tbl_valid/we/is_load  per-stage entry flags
//   tbl_rd                per-stage destination register
//   hit, stage, is_load   match found, its stage number (1..N), and whether
//                         that writer is a load
module hazard_fwd_match #(
  parameter int NUM_STAGES = 2,
  parameter int REG_AW     = 5,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]                 rs,
  input  logic                              rs_used,
  input  logic [NUM_STAGES-1:0]             tbl_valid,
  input  logic [NUM_STAGES-1:0]             tbl_we,
  input  logic [NUM_STAGES-1:0]             tbl_is_load,
  input  logic [NUM_STAGES-1:0][REG_AW-1:0] tbl_rd,
  output logic                              hit,
  output logic [SEL_W-1:0]                  stage,
  output logic                              is_load
);

  logic [NUM_STAGES-1:0] match;

  // x0 is hard-wired zero: never forwarded, even if some entry "writes" it.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_match
    assign match[k] = rs_used && (rs != '0) && tbl_valid[k] && tbl_we[k] &&
                      (tbl_rd[k] == rs);
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit     = 1'b1;
        stage   = SEL_W'(k + 1);
        is_load = tbl_is_load[k];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall and post-redirect squash control
// for the Riscv151 pipeline. Tracks every in-flight writer over NUM_STAGES
// post-decode stages (X=1 .. WB=NUM_STAGES).
//   clk, reset             clock, asynchronous active-high reset
//   id_*                   decode-stage instruction fields
//   x_redirect             taken branch/jump resolved in X this cycle
//   fwd_sel_a/b            0 = regfile, k = forward from stage k
//   stall                  hold PC/decode, inject bubble (load-use)
//   kill                   squash decode slot, inject bubble
//   perf_stalls/perf_kills event counters, present only when the macro
//                          HAZARD_PERF_EN is defined
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = HZ_NUM_STAGES_DEF,
  parameter int REG_AW      = HZ_REG_AW_DEF,
  parameter int LOAD_LAT    = HZ_LOAD_LAT_DEF,
  parameter int KILL_CYCLES = HZ_KILL_CYCLES_DEF,
  parameter int SEL_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              x_redirect,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic              kill
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_kills
`endif
);

  localparam int CNT_W = $clog2(KILL_CYCLES + 1);

  // ---------------------------------------------------------------- table
  hz_flags_t [NUM_STAGES-1:0]             tbl_q, tbl_d;
  logic      [NUM_STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
  logic      [CNT_W-1:0]                  cnt_q, cnt_d;

  logic [NUM_STAGES-1:0] t_vld, t_we, t_ld;
  logic                  issue;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      t_vld[k] = tbl_q[k].valid;
      t_we[k]  = tbl_q[k].we;
      t_ld[k]  = tbl_q[k].is_load;
    end
  end

  // Entry 1 takes the decode instruction only when it actually advances;
  // stalled or squashed slots enter X as bubbles.
  always_comb begin
    tbl_d    = '0;
    rd_d     = '0;
    tbl_d[0] = issue ? '{valid: 1'b1, we: id_we, is_load: id_is_load} : '0;
    rd_d[0]  = id_rd;
    for (int k = 1; k < NUM_STAGES; k++) begin
      tbl_d[k] = tbl_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
  end

  // --------------------------------------------------------- kill counter
  // A redirect (re)loads the remaining squash count; no accumulation.
  always_comb begin
    cnt_d = cnt_q;
    if (x_redirect)        cnt_d = CNT_W'(KILL_CYCLES - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_q <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // ------------------------------------------------------- operand match
  logic             a_hit, a_ld, b_hit, b_ld;
  logic [SEL_W-1:0] a_stage, b_stage;

  hazard_fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_AW     (REG_AW),
    .SEL_W      (SEL_W)
  ) u_match_rs1 (
    .rs          (id_rs1),
    .rs_used     (id_rs1_used),
    .tbl_valid   (t_vld),
    .tbl_we      (t_we),
    .tbl_is_load (t_ld),
    .tbl_rd      (rd_q),
    .hit         (a_hit),
    .stage       (a_stage),
    .is_load     (a_ld)
  );

  hazard_fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .REG_AW     (REG_AW),
    .SEL_W      (SEL_W)
  ) u_match_rs2 (
    .rs          (id_rs2),
    .rs_used     (id_rs2_used),
    .tbl_valid   (t_vld),
    .tbl_we      (t_we),
    .tbl_is_load (t_ld),
    .tbl_rd      (rd_q),
    .hit         (b_hit),
    .stage       (b_stage),
    .is_load     (b_ld)
  );

  // ------------------------------------------------------------ outputs
  logic lu_a, lu_b, kill_raw;

  // Load data becomes forwardable only once the load is past LOAD_LAT.
  assign lu_a     = a_hit && a_ld && (32'(a_stage) <= 32'(LOAD_LAT));
  assign lu_b     = b_hit && b_ld && (32'(b_stage) <= 32'(LOAD_LAT));
  assign kill_raw = x_redirect || (cnt_q != '0);

  // Outputs are gated by reset so they drop the instant reset asserts,
  // even with x_redirect still high. A squashed slot never stalls.
  assign kill      = kill_raw && !reset;
  assign stall     = id_valid && (lu_a || lu_b) && !kill_raw && !reset;
  assign issue     = id_valid && !stall && !kill;
  assign fwd_sel_a = (a_hit && !reset) ? a_stage : SEL_W'(FWD_REGFILE);
  assign fwd_sel_b = (b_hit && !reset) ? b_stage : SEL_W'(FWD_REGFILE);

`ifdef HAZARD_PERF_EN
  // -------------------------------------------------------- perf counters
  logic [31:0] perf_stalls_q, perf_stalls_d, perf_kills_q, perf_kills_d;

  // Plain 32-bit increment: wraps from all-ones to zero.
  always_comb begin
    perf_stalls_d = perf_stalls_q + {31'd0, stall};
    perf_kills_d  = perf_kills_q + {31'd0, kill};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls_q <= '0;
      perf_kills_q  <= '0;
    end else begin
      perf_stalls_q <= perf_stalls_d;
      perf_kills_q  <= perf_kills_d;
    end
  end

  assign perf_stalls = perf_stalls_q;
  assign perf_kills  = perf_kills_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand sequences for hazard_ctrl
// (NUM_STAGES=2, LOAD_LAT=1, KILL_CYCLES=2). Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int SW = 2;
  localparam int NV = 16;

  logic          clk, reset;
  logic          id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, x_redirect;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [SW-1:0] fwd_sel_a, fwd_sel_b;
  logic          stall, kill;
`ifdef HAZARD_PERF_EN
  logic [31:0]   perf_stalls, perf_kills;
`endif

  hazard_ctrl #(
    .NUM_STAGES  (2),
    .REG_AW      (AW),
    .LOAD_LAT    (1),
    .KILL_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_is_load  (id_is_load),
    .x_redirect  (x_redirect),
    .fwd_sel_a   (fwd_sel_a),
    .fwd_sel_b   (fwd_sel_b),
    .stall       (stall),
    .kill        (kill)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stalls (perf_stalls),
    .perf_kills  (perf_kills)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic [AW-1:0] rs1, rs2;
    logic          u1, u2;
    logic [AW-1:0] rd;
    logic          we, ld, rdr;
    logic          csel;       // fwd_sel is don't-care while stalled
    int            ea, eb;
    logic          es, ek;
  } vec_t;

  vec_t vt[NV];

  function automatic vec_t mk(int v, int rs1, int rs2, int u1, int u2, int rd,
                              int we, int ld, int rdr, int csel,
                              int ea, int eb, int es, int ek);
    vec_t r;
    r.v = v[0];  r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.u1 = u1[0]; r.u2 = u2[0];
    r.rd = AW'(rd); r.we = we[0]; r.ld = ld[0]; r.rdr = rdr[0]; r.csel = csel[0];
    r.ea = ea; r.eb = eb; r.es = es[0]; r.ek = ek[0];
    return r;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v;   id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_rs1_used = x.u1; id_rs2_used = x.u2;
    id_rd = x.rd; id_we = x.we; id_is_load = x.ld; x_redirect = x.rdr;
  endtask

  // One decode cycle: drive after the edge, sample mid-cycle.
  task automatic cyc(input int v, input int rs1, input int rs2, input int u1,
                     input int u2, input int rd, input int we, input int ld,
                     input int rdr);
    @(posedge clk);
    #1 drive(mk(v, rs1, rs2, u1, u2, rd, we, ld, rdr, 0, 0, 0, 0, 0));
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input int ea, input int eb,
                         input int es, input int ek);
    chk({tag, "_sel_a"}, fwd_sel_a, ea);
    chk({tag, "_sel_b"}, fwd_sel_b, eb);
    chk({tag, "_stall"}, stall, es);
    chk({tag, "_kill"},  kill, ek);
  endtask

  initial begin
    //            v rs1 rs2 u1 u2 rd we ld rdr cs ea eb es ek
    vt[0]  = mk(1, 1,  2,  1, 1, 5, 1, 0, 0,  1, 0, 0, 0, 0); // add x5
    vt[1]  = mk(1, 5,  5,  1, 1, 6, 1, 0, 0,  1, 1, 1, 0, 0); // sub x6,x5,x5
    vt[2]  = mk(1, 1,  2,  1, 1, 10,1, 0, 0,  1, 0, 0, 0, 0); // gap
    vt[3]  = mk(1, 6,  6,  1, 1, 11,1, 0, 0,  1, 2, 2, 0, 0); // one gap -> 2
    vt[4]  = mk(1, 1,  2,  1, 1, 12,1, 0, 0,  1, 0, 0, 0, 0);
    vt[5]  = mk(1, 1,  2,  1, 1, 13,1, 0, 0,  1, 0, 0, 0, 0);
    vt[6]  = mk(1, 11, 11, 1, 1, 14,1, 0, 0,  1, 0, 0, 0, 0); // two gaps -> 0
    vt[7]  = mk(1, 1,  0,  1, 0, 7, 1, 1, 0,  1, 0, 0, 0, 0); // lw x7
    vt[8]  = mk(1, 7,  1,  1, 1, 8, 1, 0, 0,  0, 0, 0, 1, 0); // load-use stall
    vt[9]  = mk(1, 7,  1,  1, 1, 8, 1, 0, 0,  1, 2, 0, 0, 0); // issues, sel=2
    vt[10] = mk(1, 1,  2,  1, 1, 3, 1, 0, 0,  1, 0, 0, 0, 0); // add x3
    vt[11] = mk(1, 1,  2,  1, 1, 3, 1, 0, 0,  1, 0, 0, 0, 0); // add x3
    vt[12] = mk(1, 3,  0,  1, 1, 4, 1, 0, 0,  1, 1, 0, 0, 0); // youngest wins
    vt[13] = mk(1, 1,  2,  1, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0); // writes x0
    vt[14] = mk(1, 0,  4,  1, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0); // x0 / unused rs2
    vt[15] = mk(0, 1,  2,  1, 1, 9, 1, 0, 0,  1, 1, 0, 0, 0); // empty slot

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);   // kill held low despite x_redirect
`ifdef HAZARD_PERF_EN
    chk("reset_perf_stalls", perf_stalls, 0);
    chk("reset_perf_kills",  perf_kills,  0);
`endif
    x_redirect = 1'b0;
    #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 drive(vt[i]);
      @(negedge clk);
      if (vt[i].csel) begin
        chk($sformatf("v%0d_sel_a", i), fwd_sel_a, vt[i].ea);
        chk($sformatf("v%0d_sel_b", i), fwd_sel_b, vt[i].eb);
      end
      chk($sformatf("v%0d_stall", i), stall, vt[i].es);
      chk($sformatf("v%0d_kill", i),  kill,  vt[i].ek);
    end

    // Single redirect: kill at t and t+1 only.
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 1); chk_out("r1_t0", 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 0); chk_out("r1_t1", 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 0); chk_out("r1_t2", 0, 0, 0, 0);

    // Second redirect at t+1 reloads: kill through t+2.
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 1); chk("r2_t0_kill", kill, 1);
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 1); chk("r2_t1_kill", kill, 1);
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 0); chk("r2_t2_kill", kill, 1);
    cyc(1, 0, 0, 0, 0, 20, 1, 0, 0); chk("r2_t3_kill", kill, 0);

    // Load-use coinciding with a redirect: kill wins, no stall.
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0); chk_out("r3_lw", 0, 0, 0, 0);
    cyc(1, 7, 1, 1, 1, 8, 1, 0, 1); chk("r3_t0_stall", stall, 0);
                                    chk("r3_t0_kill",  kill,  1);
    cyc(1, 7, 1, 1, 1, 8, 1, 0, 0); chk("r3_t1_stall", stall, 0);
                                    chk("r3_t1_kill",  kill,  1);
    cyc(1, 7, 1, 1, 1, 8, 1, 0, 0); chk_out("r3_t2", 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stall.
    cyc(1, 1, 0, 1, 0, 7, 1, 1, 0);
    cyc(1, 7, 7, 1, 1, 8, 1, 0, 0); chk("ar_pre_stall", stall, 1);
    #1 reset = 1'b1; x_redirect = 1'b1;
    #1 chk_out("ar_mid", 0, 0, 0, 0);
    x_redirect = 1'b0;
    #1 reset = 1'b0;
    #1 chk_out("ar_first", 0, 0, 0, 0);     // add x8,x7,x7 sees empty table
    cyc(1, 7, 8, 1, 1, 9, 1, 0, 0); chk_out("ar_second", 0, 1, 0, 0);

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 0, 7, 1, 1, 0);
      cyc(1, 7, 1, 1, 1, 8, 1, 0, 0);
      cyc(1, 7, 1, 1, 1, 8, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf_stalls", perf_stalls, 3);
    chk("perf_kills",  perf_kills,  2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
